// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_controller port between REQ_CNT
// cpu_core requesters using the rw_flag/addr/data/mask/busy/done protocol.
// Arbitration is round-robin by default; defining MEM_ARB_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins, no pointer kept).
// All outputs are registered except req_busy.
module mem_port_arbiter #(
    parameter int REQ_CNT = 2,
    parameter int IDX_BIT = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [REQ_CNT*2-1:0]   req_rw_flag,
    input  logic [REQ_CNT*32-1:0]  req_addr,
    input  logic [REQ_CNT*32-1:0]  req_write_data,
    input  logic [REQ_CNT*4-1:0]   req_write_mask,
    output logic [REQ_CNT*32-1:0]  req_read_data,
    output logic [REQ_CNT-1:0]     req_busy,
    output logic [REQ_CNT-1:0]     req_done,
    output logic [1:0]             MEM_rw_flag,
    output logic [31:0]            MEM_addr,
    output logic [31:0]            MEM_write_data,
    output logic [3:0]             MEM_write_mask,
    input  logic [31:0]            MEM_read_data,
    input  logic                   MEM_busy,
    input  logic                   MEM_done
);

    localparam logic [1:0]         FLAG_READ  = 2'b01;
    localparam logic [1:0]         FLAG_WRITE = 2'b10;
    localparam logic [IDX_BIT-1:0] LAST_IDX   = IDX_BIT'(REQ_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_BIT-1:0]   grant_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDX_BIT-1:0]   ptr_q;
`endif
    logic [1:0]           mem_rw_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;
    logic [3:0]           mem_mask_q;
    logic [REQ_CNT*32-1:0] rdata_q;
    logic [REQ_CNT-1:0]   done_q;

    logic [REQ_CNT-1:0]   valid;
    logic                 any_valid;
    logic [IDX_BIT-1:0]   win_d;
    logic                 found;
    logic [IDX_BIT-1:0]   scan;
    logic                 port_free;

    // A requester is valid only for a plain read or write; 00 and 11 are idle.
    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            valid[i] = (req_rw_flag[2*i +: 2] == FLAG_READ) ||
                       (req_rw_flag[2*i +: 2] == FLAG_WRITE);
        end
        any_valid = |valid;
    end

    // Winner selection for the next issue.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        scan  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            if (!found && valid[i]) begin
                found = 1'b1;
                win_d = IDX_BIT'(i);
            end
        end
`else
        // Scan starts one past the last winner; the index wraps at REQ_CNT,
        // not at the natural 2^IDX_BIT boundary.
        scan = ptr_q;
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
            if (!found && valid[scan]) begin
                found = 1'b1;
                win_d = scan;
            end
        end
`endif
    end

    // The port can accept a new request only while idle and the controller is free.
    always_comb begin
        port_free = (state_q == ST_IDLE) && !MEM_busy;
        req_busy  = port_free ? '0 : '1;
    end

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= LAST_IDX;
`endif
            mem_rw_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_valid && !MEM_busy) begin
                        grant_q     <= win_d;
                        mem_rw_q    <= req_rw_flag[2*win_d +: 2];
                        mem_addr_q  <= req_addr[32*win_d +: 32];
                        mem_wdata_q <= req_write_data[32*win_d +: 32];
                        mem_mask_q  <= req_write_mask[4*win_d +: 4];
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (MEM_done) begin
                        mem_rw_q        <= '0;
                        done_q[grant_q] <= 1'b1;
                        if (mem_rw_q == FLAG_READ) begin
                            rdata_q[32*grant_q +: 32] <= MEM_read_data;
                        end
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr_q           <= grant_q;
`endif
                        state_q         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // One dead cycle lets the winner retire its flag after req_done.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MEM_rw_flag    = mem_rw_q;
    assign MEM_addr       = mem_addr_q;
    assign MEM_write_data = mem_wdata_q;
    assign MEM_write_mask = mem_mask_q;
    assign req_read_data  = rdata_q;
    assign req_done       = done_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory_controller port between REQ_CNT cpu_core requesters (e.g. instruction fetch and load/store unit).
- Selects one pending request, drives it to the memory port until MEM_done, then returns read data and a one-cycle done pulse to the winner.
- Default policy is round-robin.
- Sits between cpu_core and memory_controller, using the same rw_flag/addr/data/mask/busy/done protocol on both sides.

Parameters:
REQ_CNT, 2, number of requesters (≥2)
IDX_BIT, 1, width of the grant index; must satisfy 2^IDX_BIT ≥ REQ_CNT

Ports:
CLK  input  1  clock
RST  input  1  reset; one clock; reset is asynchronous and active-low
req_rw_flag  input  REQ_CNT*2  per requester: 2'b01 read, 2'b10 write, 2'b00/2'b11 no request
req_addr  input  REQ_CNT*32  per-requester byte address
req_write_data  input  REQ_CNT*32  per-requester write data
req_write_mask  input  REQ_CNT*4  per-requester byte-enable
req_read_data  output  REQ_CNT*32  per-requester returned read data
req_busy  output  REQ_CNT  per requester: arbiter cannot accept now
req_done  output  REQ_CNT  per requester: one-cycle completion pulse
MEM_rw_flag  output  2  to memory_controller
MEM_addr  output  32  to memory_controller
MEM_write_data  output  32  to memory_controller
MEM_write_mask  output  4  to memory_controller
MEM_read_data  input  32  from memory_controller
MEM_busy  input  1  from memory_controller
MEM_done  input  1  from memory_controller

Behaviour:
- Reset (RST low, async):
  - All outputs 0; state IDLE; grant index 0.
  - Round-robin last-granted pointer set to REQ_CNT-1, so requester 0 has top priority first.
  - Reset mid-transaction abandons the transaction; MEM_rw_flag drops to 0 immediately.
- All MEM_* and req_* outputs are registered, except req_busy (combinational).
- States:
  - IDLE → BUSY: taken in cycle t when any request is valid and MEM_busy=0. The arbiter picks winner g, latches g, and registers the winner's flag/addr/data/mask onto MEM_* (visible at t+1). If MEM_busy=1, it stays in IDLE and all requests are held.
  - BUSY: MEM_* stay stable regardless of requester inputs. When MEM_done=1 in cycle d:
    - at d+1: MEM_rw_flag=0; req_done[g]=1 for exactly one cycle;
    - at d+1, reads only: req_read_data[g] = MEM_read_data sampled at d;
    - pointer = g; go to DONE.
  - DONE → IDLE: unconditional after one cycle. Requests are ignored in DONE, so the winner has one cycle to drop or change its flag after seeing req_done.
- Latency:
  - Request seen at t with port free → MEM_rw_flag valid at t+1.
  - MEM_done at d → req_done at d+1.
  - Earliest next issue is at d+3.
- Round-robin: the winner is the first valid requester scanning from pointer+1 upward, wrapping modulo REQ_CNT.
- req_busy[i] = 1 unless (state==IDLE && MEM_busy==0).
- Requester contract: hold req_rw_flag and operands stable until its req_done pulse.
- Boundaries:
  - MEM_done in IDLE or DONE: ignored.
  - Write completion: req_read_data is unchanged.
  - Non-granted req_read_data entries hold their value.
  - Flag 2'b11 is never granted.
  - Simultaneous requests: exactly one grant per transaction; no request is dropped.
  - Index arithmetic is IDX_BIT wide with explicit wrap at REQ_CNT, not at 2^IDX_BIT.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index valid requester always wins and the pointer is unused (it may be optimised away). Starvation is permitted.
- Undefined: round-robin as above.

Test Plan:
1. RST low for 3 cycles with random inputs → all registered outputs 0, req_busy=0 while MEM_busy=0; after release, first grant goes to requester 0 when all request.
2. req1 read, addr 0x00001000; MEM_done at d with MEM_read_data=0xDEADBEEF → MEM_rw_flag=2'b01 and MEM_addr=0x1000 one cycle after request; at d+1, req_done=2'b10 for one cycle, req_read_data[1]=0xDEADBEEF, MEM_rw_flag=0.
3. req0 read 0x10 and req1 write 0x20 (data 0x12345678, mask 4'b0011) held continuously → grants 0,1,0,1 in order; write cycle shows MEM_rw_flag=2'b10, data 0x12345678, mask 0011.
4. MEM_busy=1 for 10 cycles with req0 pending → MEM_rw_flag stays 0 and req_busy=2'b11; issue occurs one cycle after MEM_busy falls.
5. RST pulsed low during BUSY (before MEM_done) → MEM_rw_flag=0 the same cycle; no req_done; a late MEM_done after release is ignored.
6. With MEM_ARB_FIXED_PRIO_EN, req0 and req1 both held for 4 transactions → all 4 grants go to requester 0; without the macro they alternate.
